// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/PC path: branch-type codes, sequencer
// state encoding and the default reset PC.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_EQ   = 3'b100;
  localparam logic [2:0] BR_NE   = 3'b101;
  localparam logic [2:0] BR_LT   = 3'b110;
  localparam logic [2:0] BR_GE   = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_TRAP    = 2'd3
  } pc_state_t;

  // Register-indirect target: bit 0 is always cleared, bit 1 is left for the
  // alignment check.
  function automatic logic [31:0] jalr_target(input logic [31:0] rs1_val,
                                              input logic [31:0] imm_val);
    return (rs1_val + imm_val) & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch decision: maps the decoded branch type and the ALU flags to taken.
// Unused code 011 falls through to not-taken.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] branch,
  input  logic       less,
  input  logic       zero,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (branch)
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      BR_EQ:   taken = zero;
      BR_NE:   taken = ~zero;
      BR_LT:   taken = less;
      BR_GE:   taken = ~less;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter and fetch sequencer: fetches at pc, holds the word for
// decode, then resolves the next pc from the execute-stage branch result.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_FETCH   | if_req high at pc, waiting for if_ack
// ST_ISSUE   | instr held valid, waiting for instr_ready
// ST_RESOLVE | waiting for ex_valid to pick the next pc
// ST_TRAP    | misaligned target seen; idle until reset
module pc_gen
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        ex_valid,
  input  logic [2:0]  branch,
  input  logic        less,
  input  logic        zero,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        redirect,
  output logic        misalign
);

  pc_state_t   state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        redirect_q;
  logic        misalign_q;

  logic        taken;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        target_bad;
  logic        ack_fire;
  logic        resolve_fire;

  branch_cond u_branch_cond (
    .branch (branch),
    .less   (less),
    .zero   (zero),
    .taken  (taken)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    target = pc_plus4;
    if (taken) begin
      if (branch == BR_JALR) target = jalr_target(rs1, imm);
      else                   target = pc_q + imm;
    end
  end

  assign target_bad   = target[1];
  assign ack_fire     = (state == ST_FETCH) && if_ack;
  assign resolve_fire = (state == ST_RESOLVE) && ex_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:   if (if_ack) state_nxt = ST_ISSUE;
      ST_ISSUE:   if (instr_ready) state_nxt = ST_RESOLVE;
      ST_RESOLVE: if (ex_valid) state_nxt = target_bad ? ST_TRAP : ST_FETCH;
      ST_TRAP:    state_nxt = ST_TRAP;
      default:    state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      if (ack_fire) instr_q <= if_rdata;
      if (resolve_fire) begin
        if (target_bad) begin
          misalign_q <= 1'b1;
        end else begin
          pc_q       <= target;
          redirect_q <= (target != pc_plus4);
        end
      end
    end
  end

  // Reset gates the request so an ack arriving while reset is held is never
  // requested or consumed.
  always_comb begin
    if_req      = (state == ST_FETCH) && rst_n;
    if_addr     = pc_q;
    instr_valid = (state == ST_ISSUE);
    instr       = instr_q;
    pc          = pc_q;
    redirect    = redirect_q;
    misalign    = misalign_q;
  end

endmodule
